// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern recognizer: FSM state codes and sizing helpers.
package seq_pattern_detector_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        ARMED = 2'b01,
        LOCK  = 2'b10
    } state_t;

    // Width of the fill counter, which must hold values 0..pat_w-1.
    function automatic int fill_width(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern recognizer with overlap control, saturating match count and sticky lock.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PATTERN     = 4'b1010,
    parameter bit               OVERLAP     = 1'b1,
    parameter int               CNT_W       = 8,
    parameter bit               STOP_ON_SAT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clear,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             locked
);

    localparam int                FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);
    // Count value one below saturation: the match that lands here makes the counter all ones.
    localparam logic [CNT_W-1:0]  CNT_PRE   = ~CNT_W'(1);

    state_t             state, state_nx;
    logic [PAT_W-2:0]   hist, hist_nx;
    logic [FILL_W-1:0]  fill, fill_nx;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   cand;
    logic [PAT_W-2:0]   hist_shift;
    logic               sat_next;

    assign cand       = {hist, x};
    assign hist_shift = cand[PAT_W-2:0];
    assign sat_next   = count_sat || (match_count == CNT_PRE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            hist  <= '0;
            fill  <= '0;
            pat_q <= PATTERN;
            z_q   <= 1'b0;
        end else begin
            state <= state_nx;
            hist  <= hist_nx;
            fill  <= fill_nx;
            z_q   <= z;
            if (pat_load) begin
                pat_q <= pat_in;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        z        = 1'b0;

        case (state)
            FILL: begin
                if (en) begin
                    hist_nx = hist_shift;
                    fill_nx = fill + FILL_W'(1);
                    if (fill == FILL_LAST) begin
                        state_nx = ARMED;
                    end
                end
            end
            ARMED: begin
                if (en) begin
                    hist_nx = hist_shift;
                    if (cand == pat_q) begin
                        z = 1'b1;
                        if (!OVERLAP) begin
                            // The completing bit is dropped so the next match starts from scratch.
                            hist_nx  = '0;
                            fill_nx  = '0;
                            state_nx = FILL;
                        end
                        if (STOP_ON_SAT && sat_next) begin
                            state_nx = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                state_nx = LOCK;
            end
            default: begin
                state_nx = FILL;
                hist_nx  = '0;
                fill_nx  = '0;
            end
        endcase

        if (clear) begin
            state_nx = FILL;
            hist_nx  = '0;
            fill_nx  = '0;
            z        = 1'b0;
        end else if (pat_load) begin
            // A new pattern invalidates the history; the trap stays closed if already locked.
            state_nx = (state == LOCK) ? LOCK : FILL;
            hist_nx  = '0;
            fill_nx  = '0;
            z        = 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clock (clock),
        .reset (reset),
        .inc   (z),
        .clr   (clear),
        .count (match_count),
        .sat   (count_sat)
    );

    assign locked = (state == LOCK);

endmodule
